// File: rtl/rr_grant_arbiter_pkg.sv
// Shared arbiter definitions: handshake state encoding reused by round-robin style arbiters.
package rr_grant_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        OWNED = 2'd2
    } statetype;

endpackage

// File: rtl/rr_find_first.sv
// Round-robin search: first set request bit at or after Ptr, wrapping modulo N.
module rr_find_first #(
    parameter int unsigned BINARY_BITS = 3
) (
    input  logic [2**BINARY_BITS-1:0] Req,
    input  logic [BINARY_BITS-1:0]    Ptr,
    output logic                      Any,
    output logic [BINARY_BITS-1:0]    Idx
);

    localparam int unsigned N = 2**BINARY_BITS;

    logic [2*N-1:0]         doubled;
    logic [N-1:0]           rotated;
    logic [BINARY_BITS-1:0] offset;

    // Rotate so Ptr lands at bit 0, pick the lowest set bit, then undo the rotation.
    always_comb begin
        doubled = {Req, Req};
        rotated = N'(doubled >> Ptr);
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = BINARY_BITS'(i);
            end
        end
        Any = |Req;
        Idx = offset + Ptr;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter presenting a binary grant index with valid/ready offer and held ownership.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int unsigned BINARY_BITS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2**BINARY_BITS-1:0] Req,
    input  logic                      GrantReady,
    input  logic                      Done,
    output logic                      GrantValid,
    output logic [BINARY_BITS-1:0]    GrantIdx,
    output logic                      Busy
);

    localparam int unsigned N = 2**BINARY_BITS;

    statetype               state_q, state_d;
    logic [BINARY_BITS-1:0] ptr_q, ptr_d;
    logic [BINARY_BITS-1:0] grant_idx_q, grant_idx_d;
    logic                   grant_valid_q, grant_valid_d;
    logic                   busy_q, busy_d;

    logic                   win_any;
    logic [BINARY_BITS-1:0] win_idx;
    logic [N-1:0]           req_vec;

    assign req_vec = Req;

    // Ptr is already advanced at acceptance, so one search serves IDLE and OWNED.
    rr_find_first #(
        .BINARY_BITS(BINARY_BITS)
    ) u_find_first (
        .Req (req_vec),
        .Ptr (ptr_q),
        .Any (win_any),
        .Idx (win_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_idx_d = grant_idx_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    grant_idx_d = win_idx;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (GrantReady) begin
                    ptr_d   = grant_idx_q + 1'b1;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (Done) begin
                    if (win_any) begin
                        grant_idx_d = win_idx;
                        state_d     = OFFER;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        grant_valid_d = (state_d == OFFER);
        busy_d        = (state_d == OWNED);
    end

    assign GrantValid = grant_valid_q;
    assign GrantIdx   = grant_idx_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter with hand-computed expectations (BINARY_BITS=3).
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Req;
    logic       GrantReady;
    logic       Done;
    logic       GrantValid;
    logic [2:0] GrantIdx;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    rr_grant_arbiter #(.BINARY_BITS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .Req        (Req),
        .GrantReady (GrantReady),
        .Done       (Done),
        .GrantValid (GrantValid),
        .GrantIdx   (GrantIdx),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic gv, input logic bz, input logic [2:0] idx);
        check({tag, ".valid"}, 32'(GrantValid), 32'(gv));
        check({tag, ".busy"},  32'(Busy),       32'(bz));
        check({tag, ".idx"},   32'(GrantIdx),   32'(idx));
    endtask

    task automatic drive(input logic [7:0] r, input logic gr, input logic dn);
        Req        = r;
        GrantReady = gr;
        Done       = dn;
    endtask

    initial begin
        reset = 1'b1;
        drive(8'hFF, 1'b0, 1'b0);

        // reset held two cycles with all requests up
        step(); expect_out("rst0", 1'b0, 1'b0, 3'd0);
        step(); expect_out("rst1", 1'b0, 1'b0, 3'd0);
        reset = 1'b0;
        drive(8'h81, 1'b0, 1'b0);
        step(); expect_out("rst_release", 1'b1, 1'b0, 3'd0);

        // fairness: in OFFER idx0 ptr0, grant every other cycle
        drive(8'hFF, 1'b1, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step(); expect_out($sformatf("fair_acc%0d", k), 1'b0, 1'b1, 3'(k % 8));
            step(); expect_out($sformatf("fair_off%0d", k), 1'b1, 1'b0, 3'((k + 1) % 8));
        end

        // accept 1 (ptr=2), then finish with no requests
        drive(8'h00, 1'b1, 1'b0);
        step(); expect_out("drain_acc", 1'b0, 1'b1, 3'd1);
        drive(8'h00, 1'b0, 1'b1);
        step(); expect_out("drain_idle", 1'b0, 1'b0, 3'd1);

        // offer stability, with Done ignored in OFFER
        drive(8'h04, 1'b0, 1'b0);
        step(); expect_out("stab_offer", 1'b1, 1'b0, 3'd2);
        drive(8'h01, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(); expect_out($sformatf("stab_hold%0d", k), 1'b1, 1'b0, 3'd2);
        end
        drive(8'h00, 1'b1, 1'b0);
        step(); expect_out("stab_acc", 1'b0, 1'b1, 3'd2);

        // GrantReady ignored in OWNED
        for (int k = 0; k < 2; k++) begin
            step(); expect_out($sformatf("gr_owned%0d", k), 1'b0, 1'b1, 3'd2);
        end
        drive(8'h00, 1'b0, 1'b1);
        step(); expect_out("owned_done_idle", 1'b0, 1'b0, 3'd2);

        // Done and GrantReady ignored in IDLE
        drive(8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step(); expect_out($sformatf("idle_ign%0d", k), 1'b0, 1'b0, 3'd2);
        end
        // ptr must still be 3
        drive(8'hFF, 1'b0, 1'b0);
        step(); expect_out("ptr_kept", 1'b1, 1'b0, 3'd3);

        // wrap: reach and accept grant 7 so ptr wraps to 0
        drive(8'h80, 1'b1, 1'b0);
        step(); expect_out("wrap_acc3", 1'b0, 1'b1, 3'd3);
        drive(8'h80, 1'b0, 1'b1);
        step(); expect_out("wrap_off7", 1'b1, 1'b0, 3'd7);
        drive(8'h80, 1'b1, 1'b0);
        step(); expect_out("wrap_acc7", 1'b0, 1'b1, 3'd7);
        drive(8'h81, 1'b0, 1'b1);
        step(); expect_out("wrap_off0", 1'b1, 1'b0, 3'd0);

        // accept 0, offer and accept 6 so ptr=7
        drive(8'h40, 1'b1, 1'b0);
        step(); expect_out("wrap_acc0", 1'b0, 1'b1, 3'd0);
        drive(8'h40, 1'b0, 1'b1);
        step(); expect_out("wrap_off6", 1'b1, 1'b0, 3'd6);
        drive(8'h40, 1'b1, 1'b0);
        step(); expect_out("wrap_acc6", 1'b0, 1'b1, 3'd6);
        drive(8'h03, 1'b0, 1'b1);
        step(); expect_out("wrap7_off0", 1'b1, 1'b0, 3'd0);
        drive(8'h03, 1'b1, 1'b0);
        step(); expect_out("wrap7_acc0", 1'b0, 1'b1, 3'd0);
        drive(8'h03, 1'b0, 1'b1);
        step(); expect_out("wrap7_off1", 1'b1, 1'b0, 3'd1);

        // reset mid-OWNED after accepting 5 (ptr=6)
        drive(8'h20, 1'b1, 1'b0);
        step(); expect_out("mid_acc1", 1'b0, 1'b1, 3'd1);
        drive(8'h20, 1'b0, 1'b1);
        step(); expect_out("mid_off5", 1'b1, 1'b0, 3'd5);
        drive(8'h20, 1'b1, 1'b0);
        step(); expect_out("mid_acc5", 1'b0, 1'b1, 3'd5);
        reset = 1'b1;
        drive(8'h41, 1'b0, 1'b0);
        step(); expect_out("mid_reset", 1'b0, 1'b0, 3'd0);
        reset = 1'b0;
        step(); expect_out("mid_after", 1'b1, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
